// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and FSM state encoding.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 8;
  localparam int unsigned FRAME_BITS           = 10;
  localparam int unsigned DATA_BITS            = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; bit_end_c_o flags the last clk of each bit.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic restart_i,
  output logic bit_end_c_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign bit_end_c_o = (cnt_q == LAST);

  // Count 0..CLKS_PER_BIT-1, wrapping at bit end; restart holds the count at zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (restart_i || bit_end_c_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a four-phase REQ/ACK upstream handshake.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 XMIT_REQ,
  input  logic [DATA_BITS-1:0] XMIT_DATA,
  output logic                 XMIT_ACK,
  output logic                 XMT,
  output logic                 BUSY
);

  import uart_pkg::state_e;
  import uart_pkg::IDLE;
  import uart_pkg::START;
  import uart_pkg::DATA;
  import uart_pkg::STOP;

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_e               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 xmt_q;
  logic                 ack_q;
  logic                 busy_q;
  logic                 bit_end_c;
  logic                 accept_c;

  assign accept_c = XMIT_REQ && !ack_q;
  assign XMIT_ACK = ack_q;
  assign XMT      = xmt_q;
  assign BUSY     = busy_q;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .clr        (clr),
    .restart_i  (state_q == IDLE),
    .bit_end_c_o(bit_end_c)
  );

  // Frame sequencer: capture, start bit, LSB-first data, stop bit, handshake release.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      xmt_q   <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (ack_q && !XMIT_REQ) begin
        ack_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            shift_q <= XMIT_DATA;
            ack_q   <= 1'b1;
            xmt_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end_c) begin
            xmt_q   <= shift_q[0];
            idx_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end_c) begin
            if (idx_q == LAST_IDX) begin
              xmt_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= shift_q >> 1;
              xmt_q   <= shift_q[1];
              idx_q   <= idx_q + IDX_W'(1);
            end
          end
        end
        STOP: begin
          if (bit_end_c) begin
            // A waiting request starts on the stop bit's last edge: exactly one stop bit between frames.
            if (accept_c) begin
              shift_q <= XMIT_DATA;
              ack_q   <= 1'b1;
              xmt_q   <= 1'b0;
              state_q <= START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
